oscillator_readout_ctrl: RTL and testbench
==========================================

Name: oscillator_readout_ctrl

Overview:
- Synchronous controller that drives one ring-oscillator TDC channel and reads its result.
- Issues clear/enable windows to the oscillator, i.e. drives its enable and reset inputs.
- Synchronises the oscillator's asynchronous hasValue flag, waits for the count to settle, then captures the count.
- Presents the captured count to downstream logic over a valid/ready handshake, with timeout protection on the measurement window.

Parameters:
- BIT_COUNT, 32: width of the oscillator count and of the result.
- SYNC_STAGES, 2: flip-flop stages on the oscHasValue synchroniser (minimum 2).
- SETTLE_CYCLES, 2: clk cycles waited after the synchronised hasValue rises, before sampling oscCount.
- CLEAR_CYCLES, 2: clk cycles oscReset is held high before each measurement.
- TIMEOUT_CYCLES, 1024: maximum RUN length in clk cycles before a forced stop.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a measurement.
- stop  in  1  single-cycle request to end the measurement window.
- oscEnable  out  1  oscillator enable (measurement window).
- oscReset  out  1  oscillator counter reset.
- oscCount  in  BIT_COUNT  oscillator count (asynchronous domain; valid only once settled).
- oscHasValue  in  1  oscillator done flag (asynchronous).
- measValid  out  1  result available.
- measReady  in  1  downstream accepts result.
- measCount  out  BIT_COUNT  captured count.
- measTimeout  out  1  result was produced by a forced stop.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: synchronous, active-high, dominates every other input. All outputs are 0 on the clk edge where reset is sampled high. Synchroniser flops clear to 0. FSM goes to IDLE.
- Reset mid-operation: oscEnable drops within one clk. Any pending result is discarded.
- FSM states: IDLE, CLEAR, RUN, WAIT_DONE, SETTLE, HOLD.
- IDLE:
  - start=1 -> CLEAR.
  - stop is ignored.
- CLEAR:
  - oscReset=1, oscEnable=0 for exactly CLEAR_CYCLES cycles, then -> RUN.
- RUN:
  - oscEnable=1, oscReset=0. A run counter counts cycles spent in RUN.
  - stop is latched when it arrives. The latched stop is honoured only once the counter reaches SYNC_STAGES+1, so the stale hasValue has time to clear through the synchroniser.
  - Latched stop -> WAIT_DONE.
  - If the counter reaches TIMEOUT_CYCLES without a stop -> WAIT_DONE, with the timeout flag set.
  - start and stop in the same cycle while in IDLE: start is taken, that stop is ignored.
  - A stop arriving on the same cycle as the timeout is treated as a normal stop; the timeout flag stays 0.
- WAIT_DONE:
  - oscEnable=0.
  - Synchronised hasValue=1 -> SETTLE.
  - No timeout here: the oscillator sets hasValue on the enable fall.
- SETTLE:
  - Wait SETTLE_CYCLES cycles.
  - On the last settle cycle, register oscCount into measCount and load measTimeout from the timeout flag.
  - Then -> HOLD.
- HOLD:
  - measValid=1. measCount and measTimeout are held stable.
  - measReady=1 -> IDLE, with measValid=0 on the next cycle.
  - Latency from the oscEnable fall to measValid is SYNC_STAGES+SETTLE_CYCLES+1 clk cycles.
- start:
  - Ignored while busy=1.
  - A start in the same cycle as the HOLD handshake is also ignored.
- Widths and counters:
  - measCount equals oscCount exactly; no arithmetic.
  - Run counter width is $clog2(TIMEOUT_CYCLES+1) and saturates (never wraps).
  - Clear and settle counters are sized to their parameters.
- busy is high in all states except IDLE.

Test Plan:
- Nominal run: behavioural oscillator adds 3 counts per clk. start, then stop 10 cycles into RUN -> oscEnable high for 10 cycles; measCount=30±3, measTimeout=0; measValid rises 5 cycles after the oscEnable fall (defaults).
- Early stop: stop on the first RUN cycle -> oscEnable held for exactly 3 cycles; WAIT_DONE does not exit on the stale hasValue; measCount=9±3.
- Timeout: TIMEOUT_CYCLES=16, no stop -> oscEnable high for 16 cycles; measTimeout=1; measCount=48±3.
- Backpressure: measReady held 0 for 20 cycles after measValid -> measValid, measCount and measTimeout stable throughout; return to IDLE one cycle after measReady=1.
- Reset mid-RUN: reset pulsed at RUN cycle 5 -> all outputs 0 on the next edge, FSM in IDLE; a following start produces a normal result uncorrupted by the aborted run.
- Start while busy: start pulses in CLEAR, RUN, SETTLE and on the HOLD handshake cycle -> all ignored, exactly one result per accepted start; oscReset pulse length equals CLEAR_CYCLES each time.

Source files
------------

// File: rtl/oscillator_readout_ctrl.sv
// rtl/oscillator_readout_ctrl.sv - ring-oscillator TDC channel sequencing and result capture
module oscillator_readout_ctrl #(
    parameter int BIT_COUNT      = 32,
    parameter int SYNC_STAGES    = 2,
    parameter int SETTLE_CYCLES  = 2,
    parameter int CLEAR_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    output logic                 oscEnable,
    output logic                 oscReset,
    input  logic [BIT_COUNT-1:0] oscCount,
    input  logic                 oscHasValue,
    output logic                 measValid,
    input  logic                 measReady,
    output logic [BIT_COUNT-1:0] measCount,
    output logic                 measTimeout,
    output logic                 busy
);

    localparam int RW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW = $clog2(CLEAR_CYCLES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [RW-1:0] RUN_LIMIT   = RW'(TIMEOUT_CYCLES);
    localparam logic [RW-1:0] STOP_MIN    = RW'(SYNC_STAGES + 1);
    localparam logic [CW-1:0] CLEAR_LAST  = CW'(CLEAR_CYCLES);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_WAIT_DONE,
        ST_SETTLE,
        ST_HOLD
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] hv_sync;
    logic                   has_value_s;
    logic [RW-1:0]          run_cnt;
    logic [CW-1:0]          clear_cnt;
    logic [SW-1:0]          settle_cnt;
    logic                   stop_latched;
    logic                   stop_pending;
    logic                   timeout_flag;

    assign has_value_s  = hv_sync[SYNC_STAGES-1];
    // A stop seen this cycle counts as pending even before it is latched.
    assign stop_pending = stop_latched | stop;

    always_ff @(posedge clk) begin
        if (reset) begin
            hv_sync <= '0;
        end else begin
            hv_sync <= {hv_sync[SYNC_STAGES-2:0], oscHasValue};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            oscEnable    <= 1'b0;
            oscReset     <= 1'b0;
            measValid    <= 1'b0;
            measCount    <= '0;
            measTimeout  <= 1'b0;
            busy         <= 1'b0;
            run_cnt      <= '0;
            clear_cnt    <= '0;
            settle_cnt   <= '0;
            stop_latched <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_CLEAR;
                        oscReset  <= 1'b1;
                        busy      <= 1'b1;
                        clear_cnt <= CW'(1);
                    end
                end

                ST_CLEAR: begin
                    if (clear_cnt == CLEAR_LAST) begin
                        state        <= ST_RUN;
                        oscReset     <= 1'b0;
                        oscEnable    <= 1'b1;
                        run_cnt      <= RW'(1);
                        stop_latched <= 1'b0;
                    end else begin
                        clear_cnt <= clear_cnt + 1'b1;
                    end
                end

                ST_RUN: begin
                    // The stop is held off until the stale hasValue from the
                    // previous measurement has drained out of the synchroniser.
                    if (stop_pending && (run_cnt >= STOP_MIN)) begin
                        state        <= ST_WAIT_DONE;
                        oscEnable    <= 1'b0;
                        timeout_flag <= 1'b0;
                    end else if (run_cnt >= RUN_LIMIT) begin
                        state        <= ST_WAIT_DONE;
                        oscEnable    <= 1'b0;
                        timeout_flag <= ~stop_pending;
                    end else begin
                        stop_latched <= stop_pending;
                        if (run_cnt != {RW{1'b1}}) begin
                            run_cnt <= run_cnt + 1'b1;
                        end
                    end
                end

                ST_WAIT_DONE: begin
                    // The oscillator raises hasValue on the enable fall, so no
                    // timeout is needed here.
                    if (has_value_s) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= SW'(1);
                    end
                end

                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state       <= ST_HOLD;
                        measCount   <= oscCount;
                        measTimeout <= timeout_flag;
                        measValid   <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end

                ST_HOLD: begin
                    if (measReady) begin
                        state     <= ST_IDLE;
                        measValid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    oscEnable <= 1'b0;
                    oscReset  <= 1'b0;
                    measValid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oscillator_readout_ctrl.sv
// tb/tb_oscillator_readout_ctrl.sv - self-checking bench for oscillator_readout_ctrl
module tb_oscillator_readout_ctrl;

    localparam int BITS    = 32;
    localparam int SYNC    = 2;
    localparam int SETTLE  = 2;
    localparam int CLR     = 2;
    localparam int TMO     = 16;
    localparam int LATENCY = SYNC + SETTLE + 1;
    localparam int RATE    = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            stop;
    logic            osc_enable;
    logic            osc_reset;
    logic [BITS-1:0] osc_count;
    logic            osc_has_value;
    logic            meas_valid;
    logic            meas_ready;
    logic [BITS-1:0] meas_count;
    logic            meas_timeout;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit prev_en  = 1'b0;

    oscillator_readout_ctrl #(
        .BIT_COUNT     (BITS),
        .SYNC_STAGES   (SYNC),
        .SETTLE_CYCLES (SETTLE),
        .CLEAR_CYCLES  (CLR),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .oscEnable   (osc_enable),
        .oscReset    (osc_reset),
        .oscCount    (osc_count),
        .oscHasValue (osc_has_value),
        .measValid   (meas_valid),
        .measReady   (meas_ready),
        .measCount   (meas_count),
        .measTimeout (meas_timeout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Behavioural oscillator: counts RATE per enabled clk, hasValue rises on
    // the enable fall and clears on the enable rise (stale across CLEAR).
    always @(posedge clk) begin
        #2;
        if (osc_reset) osc_count = '0;
        else if (osc_enable) osc_count = osc_count + 32'(RATE);
        if (osc_enable && !prev_en) osc_has_value = 1'b0;
        if (!osc_enable && prev_en) osc_has_value = 1'b1;
        prev_en = osc_enable;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_near(input string name, input longint act, input longint exp, input longint tol);
        n_checks++;
        if (act < exp - tol || act > exp + tol) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".oscEnable"}, osc_enable, 0);
        chk({tag, ".oscReset"}, osc_reset, 0);
        chk({tag, ".measValid"}, meas_valid, 0);
        chk({tag, ".measCount"}, meas_count, 0);
        chk({tag, ".measTimeout"}, meas_timeout, 0);
        chk({tag, ".busy"}, busy, 0);
    endtask

    // Reference: enable length is the stop point, pushed out to SYNC+1 for
    // early stops, or the full timeout if no stop arrives within it.
    function automatic void ref_model(input int stop_at, output int en, output bit to);
        if (stop_at == 0 || stop_at > TMO) begin
            en = TMO;
            to = 1'b1;
        end else begin
            en = (stop_at < SYNC + 1) ? SYNC + 1 : stop_at;
            to = 1'b0;
        end
    endfunction

    task automatic run_vec(input string tag, input int stop_at, input bit stop_w_start,
                           input int rdy, input bit noise,
                           input int exp_en, input bit exp_to, input int exp_cnt);
        int clr;
        int en;
        int lat;
        int g;
        bit stable;
        logic [BITS-1:0] cap_cnt;
        logic            cap_to;

        start = 1'b1;
        stop  = stop_w_start;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk({tag, ".busy_after_start"}, busy, 1);

        clr = 0;
        g   = 0;
        while (osc_reset && g < 50) begin
            clr++;
            g++;
            start = noise;
            chk({tag, ".en_low_in_clear"}, osc_enable, 0);
            tick();
        end
        start = 1'b0;
        chk({tag, ".clear_len"}, clr, CLR);

        en = 0;
        g  = 0;
        while (osc_enable && g < 100) begin
            en++;
            g++;
            stop  = (en == stop_at);
            start = noise && (en == 2);
            tick();
            stop  = 1'b0;
            start = 1'b0;
        end
        chk({tag, ".enable_len"}, en, exp_en);

        lat = 0;
        while (!meas_valid && lat < 100) begin
            start = noise;
            tick();
            lat++;
        end
        chk({tag, ".valid_latency"}, lat, LATENCY);
        chk({tag, ".timeout_flag"}, meas_timeout, exp_to);
        chk_near({tag, ".count"}, meas_count, exp_cnt, RATE);

        cap_cnt = meas_count;
        cap_to  = meas_timeout;
        stable  = 1'b1;
        for (int i = 0; i < rdy; i++) begin
            tick();
            if (!meas_valid || meas_count != cap_cnt || meas_timeout != cap_to) stable = 1'b0;
        end
        chk({tag, ".hold_stable"}, stable, 1);

        meas_ready = 1'b1;
        start      = noise;
        tick();
        meas_ready = 1'b0;
        start      = 1'b0;
        chk({tag, ".valid_dropped"}, meas_valid, 0);
        chk({tag, ".idle_after_ack"}, busy, 0);
        tick();
        chk({tag, ".still_idle"}, busy, 0);
        chk({tag, ".no_reset_pulse"}, osc_reset, 0);
    endtask

    typedef struct {
        int stop_at;
        bit stop_w_start;
        int ready_delay;
        bit noise;
        int exp_en;
        bit exp_to;
        int exp_cnt;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int en;
        bit to;
        int sa;

        tbl[0] = '{10, 1'b0, 0,  1'b0, 10, 1'b0, 30};
        tbl[1] = '{1,  1'b0, 0,  1'b0, 3,  1'b0, 9};
        tbl[2] = '{2,  1'b0, 1,  1'b0, 3,  1'b0, 9};
        tbl[3] = '{4,  1'b0, 2,  1'b0, 4,  1'b0, 12};
        tbl[4] = '{0,  1'b0, 0,  1'b0, 16, 1'b1, 48};
        tbl[5] = '{16, 1'b0, 0,  1'b0, 16, 1'b0, 48};
        tbl[6] = '{0,  1'b1, 0,  1'b0, 16, 1'b1, 48};
        tbl[7] = '{5,  1'b0, 20, 1'b0, 5,  1'b0, 15};
        tbl[8] = '{8,  1'b0, 1,  1'b1, 8,  1'b0, 24};

        reset         = 1'b1;
        start         = 1'b0;
        stop          = 1'b0;
        meas_ready    = 1'b0;
        osc_count     = '0;
        osc_has_value = 1'b0;
        tick();
        start = 1'b1;
        stop  = 1'b1;
        tick();
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk_all_zero("reset");
        reset = 1'b0;
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("idle_ignores_stop", busy, 0);

        for (int i = 0; i < 9; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i].stop_at, tbl[i].stop_w_start,
                    tbl[i].ready_delay, tbl[i].noise,
                    tbl[i].exp_en, tbl[i].exp_to, tbl[i].exp_cnt);
        end

        // Reset pulsed on RUN cycle 5, then a clean measurement.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int g = 0; g < 50 && osc_reset; g++) tick();
        for (int i = 1; i < 5; i++) tick();
        chk("midrun.enable_before_reset", osc_enable, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_all_zero("midrun");
        tick();
        chk("midrun.idle", busy, 0);
        run_vec("after_reset", 7, 1'b0, 0, 1'b0, 7, 1'b0, 21);

        for (int i = 0; i < 40; i++) begin
            sa = int'($urandom_range(0, TMO + 2));
            ref_model(sa, en, to);
            run_vec($sformatf("rnd%0d", i), sa, 1'(($urandom_range(0, 3)) == 0),
                    int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                    en, to, en * RATE);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
